// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ control path.
// SUBLEQ_STEP_EN adds the single-step wait state.
package subleq_pkg;

  localparam int unsigned DefAw     = 8;
  localparam int unsigned DefDw     = 8;
  localparam int unsigned INSTR_LEN = 3;
  localparam int unsigned HLT_ADDR  = 0;

  typedef enum logic [3:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StFetchC,
    StLoadA,
    StLoadB,
    StWrite,
    StBranch,
    StHalt
`ifdef SUBLEQ_STEP_EN
    , StStepWait
`endif
  } state_e;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: res = opB - opA (wrapping) and the "less than or equal to zero" flag.
module subleq_alu
  import subleq_pkg::*;
#(
  parameter int unsigned DW = DefDw
) (
  input  logic [DW-1:0] op_a_i,
  input  logic [DW-1:0] op_b_i,
  output logic [DW-1:0] res_o,
  output logic          leq_o
);

  assign res_o = op_b_i - op_a_i;
  assign leq_o = res_o[DW-1] | (res_o == '0);

endmodule

// File: rtl/subleq_ctrl.sv
// Instruction sequencer for the SUBLEQ core: fetch A/B/C, load operands, write back, branch.
// Optional SUBLEQ_STEP_EN adds step_i and a wait state after every instruction.
module subleq_ctrl
  import subleq_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
`ifdef SUBLEQ_STEP_EN
  input  logic          step_i,
`endif
  input  logic [AW-1:0] pc_i,
  output logic [AW-1:0] pc_new_o,
  output logic          pc_we_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          busy_o,
  output logic          halted_o
);

  localparam logic [AW-1:0] HltPc  = AW'(HLT_ADDR);
  localparam logic [AW-1:0] InstrLen = AW'(INSTR_LEN);
  localparam logic [AW-1:0] AddrOne  = AW'(1);

  state_e        state_q;
  logic [AW-1:0] a_q, b_q, c_q;
  logic [DW-1:0] op_a_q, op_b_q;
  logic [AW-1:0] pc_new_q, mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          pc_we_q, mem_req_q, mem_we_q;

  logic [DW-1:0] alu_op_b, alu_res;
  logic          alu_leq;

  // In LOAD_B the operand is still on the bus, so the write data can be registered at its ack.
  assign alu_op_b = (state_q == StLoadB) ? mem_rdata_i : op_b_q;

  subleq_alu #(
    .DW(DW)
  ) u_alu (
    .op_a_i(op_a_q),
    .op_b_i(alu_op_b),
    .res_o (alu_res),
    .leq_o (alu_leq)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      pc_new_q    <= '0;
      pc_we_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run_i) begin
            if (pc_i == HltPc) begin
              state_q <= StHalt;
            end else begin
              state_q    <= StFetchA;
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_i;
            end
          end
        end
        StFetchA: begin
          if (mem_ack_i) begin
            a_q        <= AW'(mem_rdata_i);
            mem_addr_q <= mem_addr_q + AddrOne;
            state_q    <= StFetchB;
          end
        end
        StFetchB: begin
          if (mem_ack_i) begin
            b_q        <= AW'(mem_rdata_i);
            mem_addr_q <= mem_addr_q + AddrOne;
            state_q    <= StFetchC;
          end
        end
        StFetchC: begin
          if (mem_ack_i) begin
            c_q        <= AW'(mem_rdata_i);
            mem_addr_q <= a_q;
            state_q    <= StLoadA;
          end
        end
        StLoadA: begin
          if (mem_ack_i) begin
            op_a_q     <= mem_rdata_i;
            mem_addr_q <= b_q;
            state_q    <= StLoadB;
          end
        end
        StLoadB: begin
          if (mem_ack_i) begin
            op_b_q      <= mem_rdata_i;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= alu_res;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            pc_new_q  <= alu_leq ? c_q : pc_i + InstrLen;
            pc_we_q   <= 1'b1;
            state_q   <= StBranch;
          end
        end
        StBranch: begin
          pc_we_q <= 1'b0;
          if (pc_new_q == HltPc) begin
            state_q <= StHalt;
`ifdef SUBLEQ_STEP_EN
          end else begin
            state_q <= StStepWait;
          end
`else
          end else if (run_i) begin
            // pc_i only reflects pc_new after this edge, so fetch from the registered copy.
            state_q    <= StFetchA;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_new_q;
          end else begin
            state_q <= StIdle;
          end
`endif
        end
`ifdef SUBLEQ_STEP_EN
        StStepWait: begin
          if (!run_i) begin
            state_q <= StIdle;
          end else if (step_i) begin
            state_q    <= StFetchA;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_i;
          end
        end
`endif
        StHalt: state_q <= StHalt;
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          pc_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_new_o    = pc_new_q;
  assign pc_we_o     = pc_we_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign halted_o    = (state_q == StHalt);
`ifdef SUBLEQ_STEP_EN
  assign busy_o = !(state_q inside {StIdle, StHalt, StStepWait});
`else
  assign busy_o = !(state_q inside {StIdle, StHalt});
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: memory model with wait states, PC register model, write/PC scoreboards.
// Step scenario is built only when SUBLEQ_STEP_EN is defined.
module tb_subleq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
`ifdef SUBLEQ_STEP_EN
  logic       step = 1'b0;
`endif
  logic       pc_load_en = 1'b0;
  logic [7:0] pc_load = '0;
  logic [7:0] pc_reg = '0;
  logic [7:0] pc_new, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       pc_we, mem_req, mem_we, busy, halted;
  logic       mem_ack = 1'b0;

  logic [7:0]  mem [256];
  int          waits = 0;
  int          wcnt = 0;
  bit          spurious = 1'b0;
  logic [15:0] obs_wr[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  obs_rd[$];
  logic [7:0]  obs_pc[$];
  logic [7:0]  exp_pc[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  subleq_ctrl #(
    .AW(8),
    .DW(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (run),
`ifdef SUBLEQ_STEP_EN
    .step_i     (step),
`endif
    .pc_i       (pc_reg),
    .pc_new_o   (pc_new),
    .pc_we_o    (pc_we),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack),
    .busy_o     (busy),
    .halted_o   (halted)
  );

  always @(posedge clk) begin
    if (pc_load_en) pc_reg <= pc_load;
    else if (pc_we) pc_reg <= pc_new;
  end

  // Memory model: decides ack on the falling edge so the DUT samples a settled value.
  always @(negedge clk) begin
    if (pc_we) obs_pc.push_back(pc_new);
    if (rst_n && mem_req) begin
      if (wcnt >= waits) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          obs_wr.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr];
          obs_rd.push_back(mem_addr);
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = spurious;
      mem_rdata = spurious ? 8'hA5 : 8'h00;
      wcnt = 0;
    end
  end

  task automatic do_reset();
    run = 1'b0;
`ifdef SUBLEQ_STEP_EN
    step = 1'b0;
`endif
    waits = 0;
    spurious = 1'b0;
    obs_wr.delete(); exp_wr.delete(); obs_rd.delete(); obs_pc.delete(); exp_pc.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_load = v;
    pc_load_en = 1'b1;
    @(negedge clk);
    pc_load_en = 1'b0;
  endtask

  task automatic load_instr(input logic [7:0] p, input logic [7:0] a, b, c);
    logic [7:0] p1, p2;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    mem[p] = a; mem[p1] = b; mem[p2] = c;
  endtask

  // One instruction, run dropped after the first fetch cycle; scoreboard checks writes and PC.
  task automatic run_one(input string nm, input logic [7:0] p, a, b, c, va, vb,
                         input int w);
    logic [7:0] res, pn, p1, p2;
    logic [15:0] ew, ow;
    int cyc, exp_cyc;
    bit seen;
    do_reset();
    load_instr(p, a, b, c);
    mem[a] = va;
    mem[b] = vb;
    res = vb - va;
    pn = (res[7] || res == 8'd0) ? c : p + 8'd3;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    exp_wr.push_back({b, res});
    exp_pc.push_back(pn);
    exp_cyc = 6 * (w + 1) + 1;
    set_pc(p);
    waits = w;
    run = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) run = 1'b0;
      if (pc_we) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc !== exp_cyc) begin
      n_bad++;
      $display("FAIL %s latency: pc_we seen=%0d at cycle %0d, required cycle %0d",
               nm, seen, cyc, exp_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({pc_we, busy, halted, mem_req} !== {1'b0, 1'b0, (pn == 8'd0), 1'b0}) begin
      n_bad++;
      $display("FAIL %s after-branch: pc_we/busy/halted/req=%b%b%b%b, required 00%b0",
               nm, pc_we, busy, halted, mem_req, (pn == 8'd0));
    end
    n_cmp++;
    if (obs_rd.size() != 5 || obs_rd[0] !== p || obs_rd[1] !== p1 || obs_rd[2] !== p2 ||
        obs_rd[3] !== a || obs_rd[4] !== b) begin
      n_bad++;
      $display("FAIL %s reads: %0d reads, first %0d %0d %0d, required %0d %0d %0d %0d %0d",
               nm, obs_rd.size(), obs_rd[0], obs_rd[1], obs_rd[2], p, p1, p2, a, b);
    end
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 16'hxxxx;
      n_cmp++;
      if (ow !== ew) begin
        n_bad++;
        $display("FAIL %s write: got addr %h data %h, required addr %h data %h",
                 nm, ow[15:8], ow[7:0], ew[15:8], ew[7:0]);
      end
    end
    while (exp_pc.size() > 0) begin
      ew[7:0] = exp_pc.pop_front();
      ow[7:0] = (obs_pc.size() > 0) ? obs_pc.pop_front() : 8'hxx;
      n_cmp++;
      if (ow[7:0] !== ew[7:0]) begin
        n_bad++;
        $display("FAIL %s pc_new: got %0d, required %0d", nm, ow[7:0], ew[7:0]);
      end
    end
    n_cmp++;
    if (obs_pc.size() != 0 || obs_wr.size() != 0 || pc_reg !== pn) begin
      n_bad++;
      $display("FAIL %s extra: pc pulses %0d writes %0d pc_reg %0d, required 0 0 %0d",
               nm, obs_pc.size(), obs_wr.size(), pc_reg, pn);
    end
  endtask

  task automatic test_reset();
    do_reset();
    spurious = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pc_we, mem_req, mem_we, mem_addr, mem_wdata, pc_new, busy, halted} !== 29'd0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: outputs %h, required 0", i,
                 {pc_we, mem_req, mem_we, mem_addr, mem_wdata, pc_new, busy, halted});
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_halt_addr();
    do_reset();
    set_pc(8'd0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({halted, busy, mem_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL halt_at_0: halted/busy/req=%b%b%b, required 100", halted, busy, mem_req);
    end
    run = 1'b0;
  endtask

  task automatic test_halt_sticky();
    run = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({halted, busy, mem_req, pc_we} !== 4'b1000) begin
      n_bad++;
      $display("FAIL halt_sticky: halted/busy/req/pc_we=%b%b%b%b, required 1000",
               halted, busy, mem_req, pc_we);
    end
    run = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ew, ow;
    int cyc;
    do_reset();
    load_instr(8'd1, 8'd10, 8'd11, 8'd40);
    load_instr(8'd4, 8'd12, 8'd13, 8'd0);
    mem[10] = 8'd2; mem[11] = 8'd9;
    mem[12] = 8'd1; mem[13] = 8'd1;
    exp_wr.push_back({8'd11, 8'd7});
    exp_wr.push_back({8'd13, 8'd0});
    exp_pc.push_back(8'd4);
    exp_pc.push_back(8'd0);
    set_pc(8'd1);
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    n_cmp++;
    if (!halted || cyc !== 15) begin
      n_bad++;
      $display("FAIL b2b halt: halted=%0d at cycle %0d, required 1 at 15", halted, cyc);
    end
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 16'hxxxx;
      n_cmp++;
      if (ow !== ew) begin
        n_bad++;
        $display("FAIL b2b write: got addr %h data %h, required addr %h data %h",
                 ow[15:8], ow[7:0], ew[15:8], ew[7:0]);
      end
    end
    while (exp_pc.size() > 0) begin
      ew[7:0] = exp_pc.pop_front();
      ow[7:0] = (obs_pc.size() > 0) ? obs_pc.pop_front() : 8'hxx;
      n_cmp++;
      if (ow[7:0] !== ew[7:0]) begin
        n_bad++;
        $display("FAIL b2b pc_new: got %0d, required %0d", ow[7:0], ew[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    load_instr(8'd1, 8'd10, 8'd11, 8'd7);
    mem[10] = 8'd5; mem[11] = 8'd3;
    set_pc(8'd1);
    waits = 3;
    run = 1'b1;
    cyc = 0;
    while (obs_rd.size() < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'd11}) begin
      n_bad++;
      $display("FAIL mid_reset load_b: req/we=%b%b addr %0d, required 10 addr 11",
               mem_req, mem_we, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_reset async: req/busy=%b%b, required 00", mem_req, busy);
    end
    run = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, halted, mem_req, pc_we} !== 4'b0000 || obs_wr.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset idle: busy/halted/req/pc_we=%b%b%b%b writes %0d, required 0000 0",
               busy, halted, mem_req, pc_we, obs_wr.size());
    end
  endtask

`ifdef SUBLEQ_STEP_EN
  task automatic test_step();
    int cyc;
    do_reset();
    load_instr(8'd1, 8'd10, 8'd11, 8'd40);
    load_instr(8'd4, 8'd12, 8'd13, 8'd20);
    mem[10] = 8'd2; mem[11] = 8'd9;
    mem[12] = 8'd1; mem[13] = 8'd1;
    set_pc(8'd1);
    run = 1'b1;
    cyc = 0;
    while (obs_pc.size() < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, mem_req, halted} !== 3'b000 || obs_pc.size() != 1) begin
      n_bad++;
      $display("FAIL step wait1: busy/req/halted=%b%b%b pc pulses %0d, required 000 1",
               busy, mem_req, halted, obs_pc.size());
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cyc = 0;
    while (obs_pc.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, mem_req} !== 2'b00 || obs_pc.size() != 2 || obs_pc[0] !== 8'd4 ||
        obs_pc[1] !== 8'd20) begin
      n_bad++;
      $display("FAIL step wait2: busy/req=%b%b pulses %0d pcs %0d %0d, required 00 2 4 20",
               busy, mem_req, obs_pc.size(), obs_pc[0], obs_pc[1]);
    end
    run = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_halt_addr();
    run_one("taken", 8'd1, 8'd10, 8'd11, 8'd7, 8'd5, 8'd3, 0);
    run_one("not_taken", 8'd1, 8'd10, 8'd11, 8'd7, 8'd5, 8'd9, 0);
    run_one("wait3", 8'd1, 8'd10, 8'd11, 8'd7, 8'd5, 8'd9, 3);
    run_one("wrap_nt", 8'd254, 8'd20, 8'd21, 8'd0, 8'd1, 8'd5, 0);
    run_one("wrap_halt", 8'd254, 8'd20, 8'd21, 8'd0, 8'd5, 8'd5, 0);
    test_halt_sticky();
    test_back_to_back();
    test_reset_mid();
`ifdef SUBLEQ_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
